// File: rtl/vram_arb_pkg.sv
// Shared constants and state type for the framebuffer write arbiter.
package vram_arb_pkg;

  localparam int unsigned DefXW      = 8;
  localparam int unsigned DefYW      = 7;
  localparam int unsigned DefCW      = 3;
  localparam int unsigned DefXMax    = 159;
  localparam int unsigned DefYMax    = 119;
  localparam logic [2:0]  DefBgColor = 3'b000;

  typedef enum logic [0:0] {
    StArb,
    StClear
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible index after last_grant_i, wrapping modulo N.
module rr_pick #(
  parameter int unsigned N   = 3,
  parameter int unsigned LgW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   eligible_i,
  input  logic [LgW-1:0] last_grant_i,
  output logic [N-1:0]   winner_o,
  output logic           valid_o
);

  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    for (int k = 1; k <= int'(N); k++) begin
      if (!valid_o && eligible_i[LgW'((int'(last_grant_i) + k) % int'(N))]) begin
        winner_o[LgW'((int'(last_grant_i) + k) % int'(N))] = 1'b1;
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vram_write_arbiter.sv
// Round-robin arbiter for the single framebuffer write port; one registered pixel write per cycle.
// Define VRAM_ARB_CLEAR_EN to add the screen-clear sweep engine (clear_req / clear_done ports).
module vram_write_arbiter
  import vram_arb_pkg::*;
#(
  parameter int unsigned    N_REQ    = 3,
  parameter int unsigned    X_W      = DefXW,
  parameter int unsigned    Y_W      = DefYW,
  parameter int unsigned    C_W      = DefCW,
  parameter int unsigned    X_MAX    = DefXMax,
  parameter int unsigned    Y_MAX    = DefYMax,
  parameter logic [C_W-1:0] BG_COLOR = DefBgColor
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ*X_W-1:0] req_x,
  input  logic [N_REQ*Y_W-1:0] req_y,
  input  logic [N_REQ*C_W-1:0] req_color,
  output logic [N_REQ-1:0]     gnt,
  output logic                 wr_en,
  output logic [X_W-1:0]       wr_x,
  output logic [Y_W-1:0]       wr_y,
  output logic [C_W-1:0]       wr_color,
  output logic                 busy
`ifdef VRAM_ARB_CLEAR_EN
  ,
  input  logic                 clear_req,
  output logic                 clear_done
`endif
);

  localparam int unsigned LgW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [X_W-1:0] XMaxL = X_W'(X_MAX);
  localparam logic [Y_W-1:0] YMaxL = Y_W'(Y_MAX);

  logic [N_REQ-1:0] gnt_q, gnt_d, eligible, winner;
  logic             pick_valid, grant_en;
  logic [LgW-1:0]   last_q, last_d, win_idx;
  logic             wr_en_q, wr_en_d;
  logic [X_W-1:0]   wr_x_q, wr_x_d, win_x;
  logic [Y_W-1:0]   wr_y_q, wr_y_d, win_y;
  logic [C_W-1:0]   wr_color_q, wr_color_d, win_color;

  // A requester is masked while its own gnt is high so stale data is never written twice.
  assign eligible = req & ~gnt_q;

  rr_pick #(
    .N   (N_REQ),
    .LgW (LgW)
  ) u_rr_pick (
    .eligible_i   (eligible),
    .last_grant_i (last_q),
    .winner_o     (winner),
    .valid_o      (pick_valid)
  );

  always_comb begin
    win_idx   = '0;
    win_x     = '0;
    win_y     = '0;
    win_color = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (winner[i]) begin
        win_idx   = LgW'(i);
        win_x     = req_x[i*X_W +: X_W];
        win_y     = req_y[i*Y_W +: Y_W];
        win_color = req_color[i*C_W +: C_W];
      end
    end
  end

`ifdef VRAM_ARB_CLEAR_EN
  arb_state_e     state_q, state_d;
  logic [X_W-1:0] cx_q, cx_d;
  logic [Y_W-1:0] cy_q, cy_d;
  logic           clear_done_q, clear_done_d;
`else
  logic unused_bg;
  assign unused_bg = ^BG_COLOR;
`endif

  always_comb begin
    gnt_d      = '0;
    wr_en_d    = 1'b0;
    wr_x_d     = wr_x_q;
    wr_y_d     = wr_y_q;
    wr_color_d = wr_color_q;
    last_d     = last_q;
    grant_en   = 1'b1;
`ifdef VRAM_ARB_CLEAR_EN
    state_d      = state_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    clear_done_d = 1'b0;
    unique case (state_q)
      StArb: begin
        if (clear_req) begin
          // Sweep starts with pixel (0,0) visible in the first CLEAR cycle.
          grant_en   = 1'b0;
          state_d    = StClear;
          cx_d       = '0;
          cy_d       = '0;
          wr_en_d    = 1'b1;
          wr_x_d     = '0;
          wr_y_d     = '0;
          wr_color_d = BG_COLOR;
        end
      end
      StClear: begin
        grant_en = 1'b0;
        if (cx_q == XMaxL && cy_q == YMaxL) begin
          state_d      = StArb;
          clear_done_d = 1'b1;
          cx_d         = '0;
          cy_d         = '0;
        end else begin
          if (cx_q == XMaxL) begin
            cx_d = '0;
            cy_d = cy_q + Y_W'(1);
          end else begin
            cx_d = cx_q + X_W'(1);
          end
          wr_en_d    = 1'b1;
          wr_x_d     = cx_d;
          wr_y_d     = cy_d;
          wr_color_d = BG_COLOR;
        end
      end
      default: state_d = StArb;
    endcase
`endif
    if (grant_en && pick_valid) begin
      gnt_d      = winner;
      wr_en_d    = (win_x <= XMaxL) && (win_y <= YMaxL);
      wr_x_d     = win_x;
      wr_y_d     = win_y;
      wr_color_d = win_color;
      last_d     = win_idx;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      gnt_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_x_q     <= '0;
      wr_y_q     <= '0;
      wr_color_q <= '0;
      last_q     <= LgW'(N_REQ - 1);
    end else begin
      gnt_q      <= gnt_d;
      wr_en_q    <= wr_en_d;
      wr_x_q     <= wr_x_d;
      wr_y_q     <= wr_y_d;
      wr_color_q <= wr_color_d;
      last_q     <= last_d;
    end
  end

`ifdef VRAM_ARB_CLEAR_EN
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q      <= StArb;
      cx_q         <= '0;
      cy_q         <= '0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      clear_done_q <= clear_done_d;
    end
  end

  assign busy       = (state_q == StClear);
  assign clear_done = clear_done_q;
`else
  assign busy = 1'b0;
`endif

  assign gnt      = gnt_q;
  assign wr_en    = wr_en_q;
  assign wr_x     = wr_x_q;
  assign wr_y     = wr_y_q;
  assign wr_color = wr_color_q;

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Bench for vram_write_arbiter: vector table, randomized model comparison, clear-sweep sequences.
module tb_vram_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [23:0] req_x;
  logic [20:0] req_y;
  logic [8:0]  req_color;
  logic [2:0]  gnt;
  logic        wr_en;
  logic [7:0]  wr_x;
  logic [6:0]  wr_y;
  logic [2:0]  wr_color;
  logic        busy;
`ifdef VRAM_ARB_CLEAR_EN
  logic        clear_req;
  logic        clear_done;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vram_write_arbiter dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .req       (req),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_color (req_color),
    .gnt       (gnt),
    .wr_en     (wr_en),
    .wr_x      (wr_x),
    .wr_y      (wr_y),
    .wr_color  (wr_color),
    .busy      (busy)
`ifdef VRAM_ARB_CLEAR_EN
    ,
    .clear_req  (clear_req),
    .clear_done (clear_done)
`endif
  );

  typedef struct packed {
    logic       rst;
    logic [2:0] req;
    logic [1:0] set;
    logic [2:0] egnt;
    logic       een;
    logic [7:0] ex;
    logic [6:0] ey;
    logic [2:0] ec;
  } vec_t;

  vec_t        tbl[18];
  logic [23:0] set_x[4];
  logic [20:0] set_y[4];
  logic [8:0]  set_c[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
`ifdef VRAM_ARB_CLEAR_EN
    clear_req = 1'b0;
`endif
    tick();
    reset = 1'b0;
  endtask

  // Randomized phase state
  bit       pend[3];
  int       px[3], py[3], pc[3];
  int       m_last, win, idx, errs, dones;
  bit [2:0] m_gnt, elig, e_gnt;
  bit       e_en;
  int       e_x, e_y, e_c;

  initial begin
    reset = 1'b0; req = '0; req_x = '0; req_y = '0; req_color = '0;
`ifdef VRAM_ARB_CLEAR_EN
    clear_req = 1'b0;
`endif
    set_x[0] = {8'd0, 8'd0, 8'd10};   set_y[0] = {7'd0, 7'd0, 7'd20};  set_c[0] = {3'd0, 3'd0, 3'd4};
    set_x[1] = {8'd0, 8'd0, 8'd160};  set_y[1] = {7'd0, 7'd0, 7'd20};  set_c[1] = {3'd0, 3'd0, 3'd4};
    set_x[2] = {8'd0, 8'd0, 8'd5};    set_y[2] = {7'd0, 7'd0, 7'd120}; set_c[2] = {3'd0, 3'd0, 3'd6};
    set_x[3] = {8'd5, 8'd3, 8'd1};    set_y[3] = {7'd6, 7'd4, 7'd2};   set_c[3] = {3'd3, 3'd2, 3'd1};

    //          rst   req     set   egnt    een   ex      ey      ec
    tbl[0]  = {1'b1, 3'b000, 2'd0, 3'b000, 1'b0, 8'd0,   7'd0,   3'd0};
    tbl[1]  = {1'b0, 3'b001, 2'd0, 3'b001, 1'b1, 8'd10,  7'd20,  3'd4};
    tbl[2]  = {1'b0, 3'b001, 2'd0, 3'b000, 1'b0, 8'd10,  7'd20,  3'd4};
    tbl[3]  = {1'b0, 3'b001, 2'd0, 3'b001, 1'b1, 8'd10,  7'd20,  3'd4};
    tbl[4]  = {1'b0, 3'b000, 2'd0, 3'b000, 1'b0, 8'd10,  7'd20,  3'd4};
    tbl[5]  = {1'b0, 3'b001, 2'd1, 3'b001, 1'b0, 8'd160, 7'd20,  3'd4};
    tbl[6]  = {1'b0, 3'b000, 2'd1, 3'b000, 1'b0, 8'd160, 7'd20,  3'd4};
    tbl[7]  = {1'b0, 3'b001, 2'd2, 3'b001, 1'b0, 8'd5,   7'd120, 3'd6};
    tbl[8]  = {1'b0, 3'b000, 2'd2, 3'b000, 1'b0, 8'd5,   7'd120, 3'd6};
    tbl[9]  = {1'b1, 3'b000, 2'd3, 3'b000, 1'b0, 8'd0,   7'd0,   3'd0};
    tbl[10] = {1'b0, 3'b111, 2'd3, 3'b001, 1'b1, 8'd1,   7'd2,   3'd1};
    tbl[11] = {1'b0, 3'b111, 2'd3, 3'b010, 1'b1, 8'd3,   7'd4,   3'd2};
    tbl[12] = {1'b0, 3'b111, 2'd3, 3'b100, 1'b1, 8'd5,   7'd6,   3'd3};
    tbl[13] = {1'b0, 3'b111, 2'd3, 3'b001, 1'b1, 8'd1,   7'd2,   3'd1};
    tbl[14] = {1'b0, 3'b101, 2'd3, 3'b100, 1'b1, 8'd5,   7'd6,   3'd3};
    tbl[15] = {1'b0, 3'b011, 2'd3, 3'b001, 1'b1, 8'd1,   7'd2,   3'd1};
    tbl[16] = {1'b0, 3'b110, 2'd3, 3'b010, 1'b1, 8'd3,   7'd4,   3'd2};
    tbl[17] = {1'b0, 3'b000, 2'd3, 3'b000, 1'b0, 8'd3,   7'd4,   3'd2};

    for (int r = 0; r < 18; r++) begin
      reset     = tbl[r].rst;
      req       = tbl[r].req;
      req_x     = set_x[tbl[r].set];
      req_y     = set_y[tbl[r].set];
      req_color = set_c[tbl[r].set];
      tick();
      reset = 1'b0;
      check($sformatf("vec%0d_gnt", r), 32'(gnt), 32'(tbl[r].egnt));
      check($sformatf("vec%0d_wr_en", r), 32'(wr_en), 32'(tbl[r].een));
      check($sformatf("vec%0d_wr_x", r), 32'(wr_x), 32'(tbl[r].ex));
      check($sformatf("vec%0d_wr_y", r), 32'(wr_y), 32'(tbl[r].ey));
      check($sformatf("vec%0d_wr_color", r), 32'(wr_color), 32'(tbl[r].ec));
      check($sformatf("vec%0d_busy", r), 32'(busy), 32'd0);
    end

    // Randomized traffic: each requester holds its pixel until granted.
    do_reset();
    m_last = 2; m_gnt = '0; e_x = 0; e_y = 0; e_c = 0;
    for (int i = 0; i < 3; i++) pend[i] = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i] = 1'b1;
          px[i] = $urandom_range(0, 170);
          py[i] = $urandom_range(0, 127);
          pc[i] = $urandom_range(0, 7);
        end
        req[i]              = pend[i];
        req_x[i*8 +: 8]     = 8'(px[i]);
        req_y[i*7 +: 7]     = 7'(py[i]);
        req_color[i*3 +: 3] = 3'(pc[i]);
      end
      for (int i = 0; i < 3; i++) elig[i] = pend[i] && !m_gnt[i];
      win = -1;
      for (int k = 1; k <= 3; k++) begin
        idx = (m_last + k) % 3;
        if (win < 0 && elig[idx]) win = idx;
      end
      e_gnt = '0;
      e_en  = 1'b0;
      if (win >= 0) begin
        e_gnt[win] = 1'b1;
        e_en = (px[win] <= 159) && (py[win] <= 119);
        e_x = px[win]; e_y = py[win]; e_c = pc[win];
        m_last = win;
      end
      tick();
      check("rnd_gnt", 32'(gnt), 32'(e_gnt));
      check("rnd_wr_en", 32'(wr_en), 32'(e_en));
      check("rnd_wr_x", 32'(wr_x), 32'(e_x));
      check("rnd_wr_y", 32'(wr_y), 32'(e_y));
      check("rnd_wr_color", 32'(wr_color), 32'(e_c));
      m_gnt = e_gnt;
      if (win >= 0) pend[win] = 1'b0;
    end

`ifdef VRAM_ARB_CLEAR_EN
    // Full sweep with a requester waiting; clear wins over the simultaneous request.
    do_reset();
    req = 3'b010;
    req_x = {8'd0, 8'd7, 8'd0}; req_y = {7'd0, 7'd8, 7'd0}; req_color = {3'd0, 3'd5, 3'd0};
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    check("clr_entry_busy", 32'(busy), 32'd1);
    check("clr_entry_gnt", 32'(gnt), 32'd0);
    errs = 0;
    for (int k = 0; k < 19200; k++) begin
      if (busy !== 1'b1 || wr_en !== 1'b1 || wr_x !== 8'(k % 160) || wr_y !== 7'(k / 160) ||
          wr_color !== 3'd0 || gnt !== 3'd0 || clear_done !== 1'b0) errs++;
      tick();
    end
    check("clr_sweep_bad_cycles", 32'(errs), 32'd0);
    check("clr_done_pulse", 32'(clear_done), 32'd1);
    check("clr_done_busy", 32'(busy), 32'd0);
    check("clr_done_wr_en", 32'(wr_en), 32'd0);
    check("clr_done_gnt", 32'(gnt), 32'd0);
    tick();
    check("post_clr_gnt", 32'(gnt), 32'b010);
    check("post_clr_wr_en", 32'(wr_en), 32'd1);
    check("post_clr_wr_x", 32'(wr_x), 32'd7);
    check("post_clr_wr_y", 32'(wr_y), 32'd8);
    check("post_clr_wr_color", 32'(wr_color), 32'd5);
    check("post_clr_done", 32'(clear_done), 32'd0);
    req = '0;

    // Reset mid-sweep, then restart and confirm clear_req is ignored while busy.
    do_reset();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (500) tick();
    check("abort_x500", 32'(wr_x), 32'd20);
    check("abort_y500", 32'(wr_y), 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_wr_en", 32'(wr_en), 32'd0);
    dones = 0;
    for (int k = 0; k < 4; k++) begin
      if (clear_done !== 1'b0) dones++;
      tick();
    end
    check("abort_no_done", 32'(dones), 32'd0);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_x", 32'(wr_x), 32'd0);
    check("restart_y", 32'(wr_y), 32'd0);
    check("restart_wr_en", 32'(wr_en), 32'd1);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    check("ignore_req_x1", 32'(wr_x), 32'd1);
    tick();
    check("ignore_req_x2", 32'(wr_x), 32'd2);
    check("ignore_req_y", 32'(wr_y), 32'd0);
    do_reset();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
